// File: rtl/mips32_multicycle_ctrl.sv
// Purpose : multi-cycle MIPS32 sequencer; walks fetch/decode/execute/memory/writeback
//           and drives every datapath enable and mux select from the state register.
// Latency : zero-wait R/I-ALU 4, lw 5, sw 4, branch/jump 3 cycles from FETCH entry.
// Backpr. : imem_req/dmem_req held until ack; TIMEOUT cycles without ack -> FAULT (bus_err).
// Ports   : clk/reset_n (async low); opcode/funct/zero from IR and ALU; imem/dmem req/ack/we;
//           ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a/b, alu_op;
//           illegal/bus_err fault pulses; retired instruction counter; state for debug.
module mips32_multicycle_ctrl #(
  parameter int TIMEOUT  = 16,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic [3:0]          state,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                illegal,
  output logic                bus_err,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3, S_WB_R = 4'd4,
    S_EXEC_I = 4'd5, S_WB_I = 4'd6, S_MEM_ADDR = 4'd7, S_MEM_RD = 4'd8, S_MEM_WB = 4'd9,
    S_MEM_WR = 4'd10, S_BRANCH = 4'd11, S_JUMP = 4'd12, S_FAULT = 4'd13
  } state_e;

  // Counter only needs to hold 0..TIMEOUT-1; the last value is the fault point.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  state_e                state_q, state_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  bus_fault_q, bus_fault_d;  // FAULT cause: 1 timeout, 0 illegal opcode
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  retire_inc;
  logic                  timed_out;

  // funct is consumed by the ALU control decoder, not by the sequencer.
  logic unused_funct;
  assign unused_funct = ^funct;

  assign timed_out = (TIMEOUT > 0) && (tmo_q == TMO_LAST);
  assign state     = state_q;
  assign retired   = retired_q;

  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;          // any state change clears it, so entry to a request state starts at 0
    bus_fault_d = bus_fault_q;
    retire_inc  = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    illegal     = 1'b0;
    bus_err     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req  = 1'b1;
        alu_src_b = 2'b01;
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timed_out) begin
          // PC untouched, so the FETCH after FAULT retries the same address.
          bus_fault_d = 1'b1;
          state_d     = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;     // branch target computed speculatively
        case (opcode)
          6'b000000:                 state_d = S_EXEC_R;
          6'b100011, 6'b101011:      state_d = S_MEM_ADDR;
          6'b000100, 6'b000101:      state_d = S_BRANCH;
          6'b000010:                 state_d = S_JUMP;
          6'b001000, 6'b001010, 6'b001011,
          6'b001100, 6'b001101:      state_d = S_EXEC_I;
          default: begin
            bus_fault_d = 1'b0;
            state_d     = S_FAULT;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire_inc = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        retire_inc = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Only lw/sw reach here; sw is the 101011 encoding.
        state_d   = (opcode == 6'b101011) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = S_MEM_WB;
        end else if (timed_out) begin
          bus_fault_d = 1'b1;
          state_d     = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_inc = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (dmem_ack) begin
          retire_inc = 1'b1;
          state_d    = S_FETCH;
        end else if (timed_out) begin
          bus_fault_d = 1'b1;
          state_d     = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_write   = opcode[0] ? ~zero : zero;  // opcode[0]: 0 beq, 1 bne
        retire_inc = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        retire_inc = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: begin
        illegal = ~bus_fault_q;
        bus_err = bus_fault_q;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, retire_inc};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      bus_fault_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      bus_fault_q <= bus_fault_d;
      retired_q   <= retired_d;
    end
  end

endmodule

// File: doc/mips32_multicycle_ctrl.md
Name: mips32_multicycle_ctrl

Overview:
- Moore-style FSM sequencer that converts the MIPS32 datapath into a multi-cycle machine.
- Steps fetch, decode, execute, memory and writeback over several clocks, driving every datapath enable and mux select.
- Handles req/ack handshakes with instruction and data memory, with timeout detection.
- Counts retired instructions. Sits beside the register file, ALU and memory blocks and replaces the single-cycle implicit sequencing.

Parameters:
TIMEOUT, 16, max cycles a memory request waits for ack before fault; 0 disables timeout
RETIRE_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
opcode  input  6  instruction[31:26] from instruction register
funct  input  6  instruction[5:0] from instruction register
zero  input  1  ALU zero flag
imem_ack  input  1  instruction memory acknowledge
dmem_ack  input  1  data memory acknowledge
state  output  4  current FSM state (debug)
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write enable (valid with dmem_req)
ir_write  output  1  load instruction register
pc_write  output  1  load PC
pc_src  output  2  00 PC+4, 01 ALUOut (branch target), 10 jump target {PC[31:28],instr[25:0],2'b00}
reg_write  output  1  register file write enable
reg_dst  output  1  0 rt, 1 rd
mem_to_reg  output  1  0 ALUOut, 1 memory data
alu_src_a  output  1  0 PC, 1 rs
alu_src_b  output  2  00 rt, 01 const 4, 10 extended imm, 11 sext imm<<2
alu_op  output  2  00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded immediate op
illegal  output  1  unsupported opcode fault pulse
bus_err  output  1  memory timeout fault pulse
retired  output  RETIRE_W  retired-instruction count

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6, MEM_ADDR=7, MEM_RD=8, MEM_WB=9, MEM_WR=10, BRANCH=11, JUMP=12, FAULT=13.
- Unused state codes go to IDLE.
- Reset (async, any time including mid-handshake):
  - state=IDLE; timeout counter=0; retired=0.
  - All control outputs 0 while in IDLE.
  - IDLE→FETCH unconditionally on the first clock after reset_n rises.
- Outputs are decoded from the state register only. The exceptions are pc_write in BRANCH (also depends on zero) and the ack-qualified strobes below.
- FETCH:
  - imem_req=1, alu_src_a=0, alu_src_b=01, alu_op=00.
  - When imem_ack=1: ir_write=1, pc_write=1, pc_src=00, and next state is DECODE.
  - Otherwise FETCH holds with imem_req high.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
  - Next state by opcode:
    - 000000 → EXEC_R
    - 100011, 101011 → MEM_ADDR
    - 000100, 000101 → BRANCH
    - 000010 → JUMP
    - 001000, 001010, 001011, 001100, 001101 → EXEC_I
    - else → FAULT with illegal=1
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 → WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11 → WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: lw→MEM_RD, sw→MEM_WR.
- MEM_RD: dmem_req=1, dmem_we=0; on dmem_ack → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: dmem_req=1, dmem_we=1; on dmem_ack → FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write = zero for beq (000100), ~zero for bne (000101).
  - Next state FETCH.
- JUMP: pc_write=1, pc_src=10 → FETCH.
- FAULT:
  - Lasts exactly one cycle; illegal or bus_err is high only during it.
  - No register, PC or memory writes; next state FETCH.
  - An illegal instruction is skipped because PC was already advanced in FETCH.
- Handshake:
  - Request stays asserted until ack is sampled high. Ack in the first request cycle is legal (zero wait).
  - Ack outside a request state is ignored.
- Timeout:
  - Counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle without ack.
  - If it reaches TIMEOUT (TIMEOUT>0) without ack → FAULT with bus_err=1.
  - A fetch timeout leaves PC unchanged, so the same fetch retries.
  - Ack in the same cycle as the timeout wins; no fault.
- retired:
  - +1 on the last cycle of each completed instruction: WB_R, WB_I, MEM_WB, MEM_WR with ack, BRANCH, JUMP.
  - FAULT never counts; the counter wraps modulo 2^RETIRE_W.
- Zero-wait latencies (cycles from FETCH entry): R-type 4, I-ALU 4, lw 5, sw 4, branch 3, jump 3.

Test Plan:
- Reset released, imem_ack tied 1, opcode=000000 funct=100000 → state 0,1,2,3,4,1. reg_write=1 only in WB_R with reg_dst=1. retired=1 after 5 clocks.
- lw (100011) with dmem_ack delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0. mem_to_reg=1 and reg_write=1 in MEM_WB. Total latency 8 cycles.
- beq with zero=1, then beq with zero=0 → pc_write=1 pc_src=01 in the first BRANCH, pc_write=0 in the second. retired increments both times.
- opcode=111111 → DECODE→FAULT. illegal high exactly 1 cycle, no reg_write/pc_write in FAULT, retired unchanged.
- TIMEOUT=16, imem_ack held 0 → FAULT after 16 FETCH cycles with bus_err pulse, no pc_write. Refetch succeeds when ack returns.
- reset_n dropped during MEM_WR with dmem_req high → state=0 and all outputs 0 asynchronously. retired=0. FETCH follows one clock after release.
